// File: rtl/alu_result_display.sv
// alu_result_display
//
// Consumer end of the lab ALU result bus. A 10-bit two's-complement result is
// captured on a load strobe and converted to sign + three BCD digits with a
// shift-add-3 (double-dabble) engine that processes one magnitude bit per clock.
// The committed value is shown on a time-multiplexed 4-digit common-anode
// 7-segment display.
//
// Optional feature: define LZB_EN to enable leading-zero blanking of the
// hundreds and tens digits. The bcd output is identical in both builds.
//
// Parameters:
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//   W            result word width, fixed at 10 (|-512| needs exactly 3 digits)
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   c      in   packed ALU result, two's complement
//   load   in   capture strobe, sampled only while idle
//   busy   out  high while a conversion runs
//   done   out  one-cycle pulse when a new value is committed
//   neg    out  committed sign (1 = negative)
//   bcd    out  committed magnitude {hundreds, tens, ones}
//   an     out  digit enables, active-low, an[3] leftmost
//   seg    out  segments {g,f,e,d,c,b,a}, active-low

module alu_result_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned W           = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] c,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic         neg,
  output logic [11:0]  bcd,
  output logic [3:0]   an,
  output logic [6:0]   seg
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SrW  = 12 + W;

  localparam logic [6:0] SegMinus = 7'h3F;
  localparam logic [6:0] SegBlank = 7'h7F;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Pre-shift correction: any BCD nibble >= 5 gets +3 so the following shift
  // carries correctly into the next decade.
  function automatic logic [11:0] add3_nibbles(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------

  state_e state_q, state_d;

  logic [SrW-1:0] sr_q;        // {bcd[11:0], remaining magnitude bits}
  logic [3:0]     step_cnt_q;
  logic           sign_q;
  logic [11:0]    bcd_q;
  logic           neg_q;
  logic           done_q;

  logic [W:0]     mag;
  logic [SrW-1:0] sr_seed;
  logic [SrW-1:0] sr_corr;
  logic [SrW-1:0] sr_step;
  logic           last_step;
  logic           accept;

  always_comb begin
    // W+1 bits so that -512 yields +512 without overflow.
    mag = c[W-1] ? (~{c[W-1], c} + {{W{1'b0}}, 1'b1}) : {1'b0, c};
    // Seeding with the magnitude MSB already in the BCD field stands in for
    // the first (correction-free) shift, leaving exactly W steps.
    sr_seed   = {{11{1'b0}}, mag};
    sr_corr   = {add3_nibbles(sr_q[SrW-1 -: 12]), sr_q[W-1:0]};
    sr_step   = {sr_corr[SrW-2:0], 1'b0};
    last_step = (step_cnt_q == 4'(W - 1));
    accept    = (state_q == StIdle) && load;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StConv;
      StConv:  if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StConv);
    done = done_q;
    neg  = neg_q;
    bcd  = bcd_q;
  end

  // Conversion datapath; bcd_q/neg_q only change at commit so the display
  // keeps showing the previous value throughout a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      step_cnt_q <= '0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        sr_q       <= sr_seed;
        step_cnt_q <= '0;
        sign_q     <= c[W-1];
      end else if (state_q == StConv) begin
        sr_q       <= sr_step;
        step_cnt_q <= step_cnt_q + 4'd1;
        if (last_step) begin
          bcd_q  <= sr_step[SrW-1 -: 12];
          neg_q  <= sign_q;
          done_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------

  logic [CntW-1:0] rcnt_q;
  logic [1:0]      idx_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;

  logic            wrap;
  logic [1:0]      idx_nxt;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            blank_hund;
  logic            blank_tens;

  always_comb begin
`ifdef LZB_EN
    blank_hund = (bcd_q[11:8] == 4'd0);
    blank_tens = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
    blank_hund = 1'b0;
    blank_tens = 1'b0;
`endif
  end

  always_comb begin
    wrap    = (rcnt_q == CntW'(REFRESH_DIV - 1));
    idx_nxt = idx_q + 2'd1;
    an_nxt  = 4'b1111;
    seg_nxt = SegBlank;
    unique case (idx_nxt)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = seg_code(bcd_q[3:0]);
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = blank_tens ? SegBlank : seg_code(bcd_q[7:4]);
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = blank_hund ? SegBlank : seg_code(bcd_q[11:8]);
      end
      2'd3: begin
        an_nxt  = 4'b0111;
        seg_nxt = neg_q ? SegMinus : SegBlank;
      end
      default: begin
        an_nxt  = 4'b1111;
        seg_nxt = SegBlank;
      end
    endcase
  end

  // The scan free-runs and is only cleared by reset, never by load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SegBlank;
    end else if (wrap) begin
      rcnt_q <= '0;
      idx_q  <= idx_nxt;
      an_q   <= an_nxt;
      seg_q  <= seg_nxt;
    end else begin
      rcnt_q <= rcnt_q + CntW'(1);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

  localparam int unsigned RDIV = 4;

`ifdef LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  c;
  logic        load;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int cur_val = 0;  // committed value according to the model

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  alu_result_display #(
    .REFRESH_DIV(RDIV),
    .W          (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .load(load),
    .busy(busy),
    .done(done),
    .neg (neg),
    .bcd (bcd),
    .an  (an),
    .seg (seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model --------------------------------------------------
  function automatic int to_int(input logic [9:0] x);
    return int'($signed(x));
  endfunction

  function automatic int abs_int(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [11:0] model_bcd(input int v);
    int m = abs_int(v);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int idx);
    int m = abs_int(v);
    int h = m / 100;
    int t = (m / 10) % 10;
    int o = m % 10;
    case (idx)
      0: return seg_tbl[o];
      1: return (Lzb && h == 0 && t == 0) ? 7'h7F : seg_tbl[t];
      2: return (Lzb && h == 0) ? 7'h7F : seg_tbl[h];
      3: return (v < 0) ? 7'h3F : 7'h7F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // ---- stimulus tasks ---------------------------------------------------
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issues one load and checks the full busy window; returns in the done cycle.
  task automatic do_conv(input logic [9:0] val);
    wait_idle();
    load = 1'b1;
    c    = val;
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check_eq($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      check_eq($sformatf("nodone_c%0d", i), 32'(done), 32'd0);
      check_eq("bcd_hold", 32'(bcd), 32'(model_bcd(cur_val)));
      @(negedge clk);
    end
    cur_val = to_int(val);
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("done", 32'(done), 32'd1);
    check_eq("bcd", 32'(bcd), 32'(model_bcd(cur_val)));
    check_eq("neg", 32'(neg), 32'(cur_val < 0));
  endtask

  task automatic run_one(input logic [9:0] val);
    do_conv(val);
    @(negedge clk);
    check_eq("done_fall", 32'(done), 32'd0);
  endtask

  // Skips the digit already registered, then checks a full scan twice.
  task automatic check_scan();
    logic [3:0] prev;
    int gap;
    prev = an;
    for (int n = 0; n < 9; n++) begin
      gap = 0;
      while (an === prev && gap < 4 * RDIV) begin
        @(negedge clk);
        gap++;
      end
      if (n > 0) begin
        check_eq("scan_period", 32'(gap), 32'(RDIV));
        check_eq($sformatf("seg_idx%0d", an_index(an)), 32'(seg),
                 32'(model_seg(cur_val, an_index(an))));
        check_eq("an_next", 32'(an_index(an)), 32'((an_index(prev) + 1) % 4));
      end
      prev = an;
    end
  endtask

  // ---- main sequence ----------------------------------------------------
  initial begin
    int dones;
    int k;
    rst  = 1'b1;
    load = 1'b0;
    c    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_neg", 32'(neg), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'd0);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;

    // First lit digit one refresh period after release.
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (an === 4'hF && k < 4 * RDIV);
    check_eq("first_lit", 32'(k), 32'(RDIV));

    run_one(10'd0);
    check_scan();
    run_one(10'h3FF);
    run_one(10'h200);
    run_one(10'd511);

    // Load while busy is ignored.
    wait_idle();
    load = 1'b1;
    c    = 10'd123;
    dones = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      load = (i == 4);
      c    = (i == 4) ? 10'd9 : 10'd123;
      if (done) dones++;
    end
    load    = 1'b0;
    cur_val = 123;
    check_eq("ignored_dones", 32'(dones), 32'd1);
    check_eq("ignored_bcd", 32'(bcd), 32'h123);
    check_eq("ignored_busy", 32'(busy), 32'd0);

    // Load accepted in the done cycle.
    do_conv(10'd37);
    do_conv(10'd250);
    @(negedge clk);
    check_eq("b2b_done_fall", 32'(done), 32'd0);

    // Randomised conversions.
    for (int i = 0; i < 12; i++) begin
      run_one(10'($urandom_range(0, 1023)));
    end

    // Display of -45 in both digit patterns.
    run_one(10'h3D3);
    check_scan();
    run_one(10'($urandom_range(0, 1023)));
    check_scan();

    // Reset in mid-conversion.
    wait_idle();
    load = 1'b1;
    c    = 10'd77;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_bcd", 32'(bcd), 32'd0);
    check_eq("mid_rst_an", 32'(an), 32'hF);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    cur_val = 0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("mid_rst_nodone", 32'(dones), 32'd0);
    check_eq("mid_rst_bcd2", 32'(bcd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Consumer end of the lab ALU result bus.
- Captures the packed 10-bit two's-complement result word on a load strobe and converts it sequentially to sign + 3 BCD digits (shift-add-3, one bit per clock).
- Drives a time-multiplexed 4-digit common-anode 7-segment display on the lab board.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range >= 2.
- W, 10, result word width; fixed at 10, because magnitude 512 needs exactly 3 BCD digits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- c  input  10  packed ALU result, two's complement, range -512..511.
- load  input  1  capture strobe; sampled only when busy=0.
- busy  output  1  high while a conversion runs.
- done  output  1  one-cycle pulse when the new value is committed.
- neg  output  1  committed sign (1 = negative).
- bcd  output  12  committed magnitude as {hundreds, tens, ones}.
- an  output  4  digit enables, active-low; an[3] is leftmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async, rst=1):
  - busy=0, done=0, neg=0, bcd=0.
  - an=4'b1111, seg=7'h7F.
  - FSM goes to IDLE; refresh counter and digit index clear to 0.
- FSM states and transitions:
  - IDLE: on a clk edge with load=1:
    - latch c;
    - compute magnitude m = c[9] ? (~c+1) as an 11-bit unsigned value : c (so -512 gives m=512);
    - latch sign = c[9];
    - clear the shift register and shift count;
    - go to CONV; busy=1.
  - CONV: each edge performs one double-dabble step: every BCD nibble >= 5 gets +3, then shift left 1 with the next magnitude bit (MSB first).
    - Exactly 10 steps are taken; bit 10 of m is consumed by seeding the shift register.
    - At the 10th step edge: commit bcd and neg, pulse done=1 for that one following cycle, set busy=0, return to IDLE.
- Latency and handshake:
  - load accepted at edge N → busy high for cycles N+1..N+10.
  - bcd/neg/done valid in the cycle after edge N+10.
  - load while busy=1 is ignored; it is not queued.
  - load in the same cycle as the done pulse is accepted, because the FSM is already in IDLE.
- Output stability: bcd and neg hold the previous committed value throughout a conversion.
- Reset mid-conversion: conversion is aborted, nothing is committed, and outputs return to their reset values.
- Display scan:
  - Free-running counter 0..REFRESH_DIV-1. On wrap, the digit index increments 0→1→2→3→0, and an/seg are registered for the new index.
  - The first lit digit appears one refresh period after reset release.
  - Index 0..2 show ones/tens/hundreds; index 3 shows the sign.
  - Digit codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Minus=3F, blank=7F.
  - Sign digit shows 3F when neg=1, 7F otherwise.
- Display update timing: committed value changes take effect on the next digit scan; the scan is never reset by load.

Optional Feature:
- Macro LZB_EN.
- When defined, leading-zero blanking:
  - hundreds digit blank if 0;
  - tens digit blank if hundreds and tens are both 0;
  - ones digit always shown.
  - The minus sign stays in digit 3; it does not move next to the number.
- When undefined, all three BCD digits are always displayed (e.g. "-007").
- bcd output is identical in both builds.

Test Plan:
- Load c=10'd0 → after 10 busy cycles: done pulse, bcd=12'h000, neg=0; sign digit seg=7F.
- Load c=10'h3FF → bcd=12'h001, neg=1. Load c=10'h200 → bcd=12'h512, neg=1. Load c=10'd511 → bcd=12'h511, neg=0.
- Load c=10'd123, then pulse load with c=10'd9 at busy cycle 4 → second load ignored; bcd=12'h123; exactly one done pulse.
- Load c=10'd77, assert rst at busy cycle 5 → busy=0, bcd=0, an=1111 immediately (async); no done pulse.
- REFRESH_DIV=4, committed -45:
  - an cycles 1110,1101,1011,0111 every 4 clks;
  - seg sequence 12,19,40,3F without LZB_EN;
  - seg sequence 12,19,7F,3F with LZB_EN.
- Load with c=10'd250 in the same cycle as a done pulse → accepted; busy rises next cycle; done after 10 cycles with bcd=12'h250.
